cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle instruction sequencer: fetch/decode/exec/wb/pc-update phase control
//
// One instruction walks FETCH -> DECODE -> EXEC -> (WB) -> PCU and then
// returns to FETCH. Opcode 8'hFF parks the sequencer in HALT until reset.
// Phase outputs (en, z, reg_we, halted) and instr_count come straight from
// flops: their next values are decoded from the next state, so each output
// changes on the same edge as the state it belongs to. ir_load is the one
// exception: it must fire in the very FETCH cycle where memory reports data,
// so it is the registered FETCH state qualified by mem_ready.

module cpu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [7:0]  opcode,
  input  logic        alu_z,
  output logic [3:0]  en,
  output logic        z,
  output logic        ir_load,
  output logic        reg_we,
  output logic        halted,
  output logic [15:0] instr_count
);

  // State encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_PCU    = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  // Opcodes with special sequencing
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_BEQ  = 8'h10;
  localparam logic [7:0] OP_JMP  = 8'h11;
  localparam logic [7:0] OP_HALT = 8'hFF;

  // Phase enables to the datapath
  localparam logic [3:0] EN_NONE   = 4'b0000;
  localparam logic [3:0] EN_FETCH  = 4'b0001;
  localparam logic [3:0] EN_DECODE = 4'b0010;
  localparam logic [3:0] EN_EXEC   = 4'b0100;
  localparam logic [3:0] EN_PCU    = 4'b1000;

  logic [2:0]  r_state;
  logic [7:0]  r_op_q;
  logic        r_zf_q;
  logic [15:0] r_instr_count;
  logic [3:0]  r_en;
  logic        r_z;
  logic        r_reg_we;
  logic        r_halted;

  logic [2:0]  w_state_nxt;
  logic [7:0]  w_op_nxt;
  logic        w_zf_nxt;
  logic [15:0] w_count_nxt;
  logic [3:0]  w_en_nxt;
  logic        w_z_nxt;
  logic        w_reg_we_nxt;
  logic        w_halted_nxt;
  logic        w_skip_wb;
  logic        w_take;

  // NOP, BEQ and JMP write no register, so they go straight from EXEC to PCU
  assign w_skip_wb = (r_op_q == OP_NOP) || (r_op_q == OP_BEQ) || (r_op_q == OP_JMP);

  // Branch decision uses the values the op/flag registers will hold in PCU,
  // which covers both the EXEC->PCU and the WB->PCU entry paths
  assign w_take = (w_op_nxt == OP_JMP) || ((w_op_nxt == OP_BEQ) && w_zf_nxt);

  // Next-state and operand-capture logic
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op_q;
    w_zf_nxt    = r_zf_q;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_op_nxt    = opcode;
        w_state_nxt = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        w_zf_nxt    = alu_z;
        w_state_nxt = w_skip_wb ? S_PCU : S_WB;
      end
      S_WB: begin
        w_state_nxt = S_PCU;
      end
      S_PCU: begin
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output values for the state about to be entered
  always_comb begin
    w_en_nxt     = EN_NONE;
    w_z_nxt      = 1'b0;
    w_reg_we_nxt = 1'b0;
    w_halted_nxt = 1'b0;
    case (w_state_nxt)
      S_FETCH:  w_en_nxt = EN_FETCH;
      S_DECODE: w_en_nxt = EN_DECODE;
      S_EXEC:   w_en_nxt = EN_EXEC;
      S_WB:     w_reg_we_nxt = 1'b1;
      S_PCU: begin
        w_en_nxt = EN_PCU;
        w_z_nxt  = w_take;
      end
      S_HALT:   w_halted_nxt = 1'b1;
      default: begin
        w_en_nxt = EN_NONE;
      end
    endcase
  end

  // Retire counter advances once per PCU cycle and wraps naturally at 16 bits
  assign w_count_nxt = (r_state == S_PCU) ? (r_instr_count + 16'd1) : r_instr_count;

  // State, operand and output registers; reset wins over every transition
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op_q        <= 8'h00;
      r_zf_q        <= 1'b0;
      r_instr_count <= 16'h0000;
      r_en          <= EN_NONE;
      r_z           <= 1'b0;
      r_reg_we      <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_op_q        <= w_op_nxt;
      r_zf_q        <= w_zf_nxt;
      r_instr_count <= w_count_nxt;
      r_en          <= w_en_nxt;
      r_z           <= w_z_nxt;
      r_reg_we      <= w_reg_we_nxt;
      r_halted      <= w_halted_nxt;
    end
  end

  assign en          = r_en;
  assign z           = r_z;
  assign reg_we      = r_reg_we;
  assign halted      = r_halted;
  assign instr_count = r_instr_count;
  assign ir_load     = (r_state == S_FETCH) && mem_ready;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer

module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mem_ready;
  logic [7:0]  opcode;
  logic        alu_z;
  logic [3:0]  en;
  logic        z;
  logic        ir_load;
  logic        reg_we;
  logic        halted;
  logic [15:0] instr_count;

  int          n_tests;
  int          n_fail;
  logic [15:0] m_count;

  cpu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_ready   (mem_ready),
    .opcode      (opcode),
    .alu_z       (alu_z),
    .en          (en),
    .z           (z),
    .ir_load     (ir_load),
    .reg_we      (reg_we),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are set just after a falling edge; outputs are sampled 1 time unit
  // later, then the task waits for the next falling edge.
  task automatic check_cycle(input string tag, input logic [3:0] e_en, input logic e_ir,
                             input logic e_we, input logic e_z, input logic e_halt);
    logic [23:0] o_vec;
    logic [23:0] e_vec;
    #1;
    o_vec = {en, ir_load, reg_we, z, halted, instr_count};
    e_vec = {e_en, e_ir, e_we, e_z, e_halt, m_count};
    n_tests++;
    assert (o_vec === e_vec) else begin
      n_fail++;
      $error("FAIL %s observed={en,ir,we,z,halt,cnt}=%h expected=%h", tag, o_vec, e_vec);
    end
    @(negedge clk);
  endtask

  // Random values on every input that should not matter in the current phase
  task automatic junk();
    start     = 1'($urandom);
    mem_ready = 1'($urandom);
    opcode    = 8'($urandom);
    alu_z     = 1'($urandom);
  endtask

  // Reference: one instruction as a phase list derived from the opcode class
  task automatic run_instr(input logic [7:0] op, input logic az, input int stall);
    logic no_wb;
    logic take;
    no_wb = (op == 8'h00) || (op == 8'h10) || (op == 8'h11);
    take  = (op == 8'h11) || ((op == 8'h10) && az);
    for (int s = 0; s < stall; s++) begin
      junk();
      mem_ready = 1'b0;
      check_cycle("fetch_stall", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    junk();
    mem_ready = 1'b1;
    check_cycle("fetch", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    junk();
    opcode = op;
    check_cycle("decode", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    if (op == 8'hFF) return;
    junk();
    alu_z = az;
    check_cycle("exec", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    if (!no_wb) begin
      junk();
      check_cycle("wb", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    junk();
    check_cycle("pcu", 4'b1000, 1'b0, 1'b0, take, 1'b0);
    m_count = m_count + 16'd1;
  endtask

  function automatic logic [7:0] rand_op();
    int pick;
    pick = int'($urandom_range(0, 5));
    case (pick)
      0:       return 8'h00;
      1:       return 8'h10;
      2:       return 8'h11;
      default: return 8'($urandom_range(8'h12, 8'hFE));
    endcase
  endfunction

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    m_count   = 16'h0000;
    rst       = 1'b1;
    start     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 8'h00;
    alu_z     = 1'b0;
    @(negedge clk);

    // Reset held with start and mem_ready high: reset must win
    check_cycle("reset_state", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    check_cycle("idle_hold", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    check_cycle("idle_start", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed: ALU op, BEQ taken/not taken, JMP, NOP, stalled fetch
    run_instr(8'h20, 1'b0, 0);
    run_instr(8'h10, 1'b1, 0);
    run_instr(8'h10, 1'b0, 0);
    run_instr(8'h11, 1'b0, 0);
    run_instr(8'h00, 1'b1, 0);
    run_instr(8'h20, 1'b1, 3);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      run_instr(rand_op(), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset during EXEC: no PCU pulse, counter cleared
    junk();
    mem_ready = 1'b1;
    check_cycle("rx_fetch", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    junk();
    opcode = 8'h11;
    check_cycle("rx_decode", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    junk();
    rst = 1'b1;
    check_cycle("rx_exec", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    rst     = 1'b0;
    start   = 1'b0;
    m_count = 16'h0000;
    check_cycle("rx_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_cycle("rx_idle2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    check_cycle("rx_restart", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(8'h00, 1'b0, 0);

    // Counter wrap: preload the retire counter to its top value, retire one NOP
    force dut.r_instr_count = 16'hFFFF;
    #0;
    release dut.r_instr_count;
    m_count = 16'hFFFF;
    run_instr(8'h00, 1'b0, 0);
    run_instr(8'h00, 1'b0, 0);

    // HALT: sticky despite start, cleared only by reset
    run_instr(8'hFF, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      junk();
      start = 1'b1;
      check_cycle("halt_hold", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    junk();
    rst = 1'b1;
    check_cycle("halt_rst_edge", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    rst     = 1'b0;
    start   = 1'b0;
    m_count = 16'h0000;
    check_cycle("halt_to_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    check_cycle("post_halt_start", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(8'h33, 1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
